// File: rtl/fb_write_arbiter.sv
// Write-port arbiter for the vga_ball framebuffer. It shares one registered
// write port between host bus writes and a fill engine that writes a constant pattern.
module fb_write_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 32,
   parameter int HOST_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_chipselect,
   input  logic              host_write,
   input  logic [ADDR_W-1:0] host_address,
   input  logic [DATA_W-1:0] host_writedata,
   output logic              host_waitrequest,
   input  logic              fill_start,
   input  logic              fill_abort,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W:0]   fill_count,
   input  logic [DATA_W-1:0] fill_pattern,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              fb_chipselect,
   output logic              fb_write,
   output logic [ADDR_W-1:0] fb_address,
   output logic [DATA_W-1:0] fb_writedata
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   localparam logic [3:0]    BURST_MAX = 4'(HOST_BURST);
   localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

   state_t              state, state_nxt;
   logic [3:0]          burst_cnt;
   logic [ADDR_W-1:0]   fill_addr;
   logic [ADDR_W:0]     fill_remaining;
   logic [DATA_W-1:0]   fill_data;
   logic                host_req, fill_pending, host_grant, fill_grant;
   logic                fill_last, start_load, start_empty;

   always_comb begin
      host_req     = host_chipselect & host_write;
      fill_pending = (state == S_FILL);
      host_grant   = host_req & (~fill_pending | (burst_cnt != BURST_MAX));
      fill_grant   = fill_pending & ~host_grant;
      fill_last    = fill_grant & (fill_remaining == REM_ONE);
      start_load   = (state == S_IDLE) & fill_start & (fill_count != '0);
      start_empty  = (state == S_IDLE) & fill_start & (fill_count == '0);
      // NOTE: waitrequest is combinational so the host sees the stall in the
      // same cycle it presents the request; registering it would lose a write.
      host_waitrequest = host_req & ~host_grant;

      state_nxt = state;
      case (state)
         S_IDLE: if (start_load) state_nxt = S_FILL;
         S_FILL: if (fill_last || fill_abort) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign fill_busy = fill_pending;

   // NOTE: every register here is updated with <= so all of them sample the
   // pre-edge values computed above, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt      <= '0;
         fill_addr      <= '0;
         fill_remaining <= '0;
         fill_data      <= '0;
         fill_done      <= 1'b0;
         fb_chipselect  <= 1'b0;
         fb_write       <= 1'b0;
         fb_address     <= '0;
         fb_writedata   <= '0;
      end else begin
         fill_done <= fill_last | start_empty;

         // Host burst accounting only matters while a fill is competing
         if (!fill_pending)   burst_cnt <= '0;
         else if (host_grant) burst_cnt <= burst_cnt + 4'd1;
         else if (fill_grant) burst_cnt <= '0;

         if (start_load) begin
            fill_addr      <= fill_base;
            fill_remaining <= fill_count;
            fill_data      <= fill_pattern;
         end else if (fill_grant) begin
            fill_addr      <= fill_addr + 1'b1;
            fill_remaining <= fill_remaining - REM_ONE;
         end

         fb_chipselect <= host_grant | fill_grant;
         fb_write      <= host_grant | fill_grant;
         if (host_grant) begin
            fb_address   <= host_address;
            fb_writedata <= host_writedata;
         end else if (fill_grant) begin
            fb_address   <= fill_addr;
            fb_writedata <= fill_data;
         end
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: stimulus queues expected fb writes and
// fill_done pulses, a negedge monitor pops and compares each output event.
module tb_fb_write_arbiter;

   localparam int ADDR_W     = 15;
   localparam int DATA_W     = 32;
   localparam int HOST_BURST = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              host_chipselect = 1'b0, host_write = 1'b0;
   logic [ADDR_W-1:0] host_address = '0;
   logic [DATA_W-1:0] host_writedata = '0;
   logic              host_waitrequest;
   logic              fill_start = 1'b0, fill_abort = 1'b0;
   logic [ADDR_W-1:0] fill_base = '0;
   logic [ADDR_W:0]   fill_count = '0;
   logic [DATA_W-1:0] fill_pattern = '0;
   logic              fill_busy, fill_done;
   logic              fb_chipselect, fb_write;
   logic [ADDR_W-1:0] fb_address;
   logic [DATA_W-1:0] fb_writedata;

   fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_BURST(HOST_BURST)) dut (
      .clk(clk), .reset(reset),
      .host_chipselect(host_chipselect), .host_write(host_write),
      .host_address(host_address), .host_writedata(host_writedata),
      .host_waitrequest(host_waitrequest),
      .fill_start(fill_start), .fill_abort(fill_abort),
      .fill_base(fill_base), .fill_count(fill_count), .fill_pattern(fill_pattern),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .fb_chipselect(fb_chipselect), .fb_write(fb_write),
      .fb_address(fb_address), .fb_writedata(fb_writedata)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              done;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
   endtask

   task automatic push(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input logic done);
      exp_t e;
      e.wr = wr; e.addr = addr; e.data = data; e.done = done;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_fill(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] count,
                             input logic [DATA_W-1:0] pat);
      fill_base = base; fill_count = count; fill_pattern = pat;
      fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
   endtask

   // Wait for the scoreboard to empty, then idle a few cycles so stray writes surface.
   task automatic drain(input string name, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check(name, 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (fb_write === 1'b1 || fill_done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_output", {62'd0, fb_write, fill_done}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("fb_write", 64'(fb_write), 64'(mon_e.wr));
            check("fb_chipselect", 64'(fb_chipselect), 64'(mon_e.wr));
            check("fill_done", 64'(fill_done), 64'(mon_e.done));
            if (mon_e.wr) begin
               check("fb_address", 64'(fb_address), 64'(mon_e.addr));
               check("fb_writedata", 64'(fb_writedata), 64'(mon_e.data));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int h, f;
      logic exp_wr;

      repeat (3) tick();
      reset = 1'b0;
      check("reset_outputs",
            {56'd0, fb_chipselect, fb_write, fill_busy, fill_done, host_waitrequest, 3'd0}, 64'd0);
      check("reset_fb_address", 64'(fb_address), 64'd0);
      check("reset_fb_writedata", 64'(fb_writedata), 64'd0);

      // Full-buffer fill with no host traffic
      for (int i = 0; i < 32768; i++)
         push(1'b1, ADDR_W'(i), 32'hFFFF_FFFF, i == 32767);
      start_fill('0, 16'h8000, 32'hFFFF_FFFF);
      check("t1_busy", 64'(fill_busy), 64'd1);
      drain("t1_drain", 40000);
      check("t1_busy_after", 64'(fill_busy), 64'd0);

      // Address wrap at the top of the buffer
      push(1'b1, 15'h7FFE, 32'hA5A5_A5A5, 1'b0);
      push(1'b1, 15'h7FFF, 32'hA5A5_A5A5, 1'b0);
      push(1'b1, 15'h0000, 32'hA5A5_A5A5, 1'b0);
      push(1'b1, 15'h0001, 32'hA5A5_A5A5, 1'b1);
      start_fill(15'h7FFE, 16'd4, 32'hA5A5_A5A5);
      drain("t2_drain", 20);

      // Continuous host stream against a 3-word fill: 4 host, 1 fill repeating
      start_fill(15'h0100, 16'd3, 32'h5A5A_0000);
      h = 0; f = 0;
      for (int k = 0; k < 17; k++) begin
         host_chipselect = 1'b1;
         host_write      = 1'b1;
         host_address    = ADDR_W'(16'h0400 + h);
         host_writedata  = 32'hC000_0000 + h;
         #1;
         exp_wr = (k % 5 == 4);
         check($sformatf("t3_waitrequest_k%0d", k), 64'(host_waitrequest), 64'(exp_wr));
         if (exp_wr) begin
            push(1'b1, ADDR_W'(16'h0100 + f), 32'h5A5A_0000, f == 2);
            f++;
         end else begin
            push(1'b1, ADDR_W'(16'h0400 + h), 32'hC000_0000 + h, 1'b0);
            h++;
         end
         tick();
      end
      host_chipselect = 1'b0;
      host_write      = 1'b0;
      drain("t3_drain", 20);
      check("t3_busy_after", 64'(fill_busy), 64'd0);

      // Zero-length fill: done pulse only, never busy
      push(1'b0, '0, '0, 1'b1);
      start_fill(15'h0010, 16'd0, 32'hDEAD_BEEF);
      check("t4_busy", 64'(fill_busy), 64'd0);
      tick();
      check("t4_busy_later", 64'(fill_busy), 64'd0);
      drain("t4_drain", 5);

      // Abort in the cycle the 10th word is granted: that word still lands
      for (int i = 0; i < 10; i++)
         push(1'b1, ADDR_W'(16'h0200 + i), 32'h1122_3344, 1'b0);
      start_fill(15'h0200, 16'd100, 32'h1122_3344);
      repeat (9) tick();
      fill_abort = 1'b1;
      tick();
      fill_abort = 1'b0;
      check("t5_abort_busy", 64'(fill_busy), 64'd0);
      drain("t5_abort_drain", 10);

      // Reset mid-fill: five words land, then everything clears with no done
      for (int i = 0; i < 5; i++)
         push(1'b1, ADDR_W'(16'h0300 + i), 32'h0BAD_F00D, 1'b0);
      start_fill(15'h0300, 16'd100, 32'h0BAD_F00D);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check("t5_reset_outputs",
            {56'd0, fb_chipselect, fb_write, fill_busy, fill_done, host_waitrequest, 3'd0}, 64'd0);
      check("t5_reset_fb_address", 64'(fb_address), 64'd0);
      check("t5_reset_fb_writedata", 64'(fb_writedata), 64'd0);
      reset = 1'b0;
      drain("t5_reset_drain", 10);
      check("t5_reset_busy_after", 64'(fill_busy), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
